watch_ctrl: RTL and testbench

Front-end controller for the stopwatch core. It turns three raw push-buttons (start, pause/resume, stop) into debounced, single-cycle command pulses (run, pause, restart, stop) plus a tick-threshold word for the core, selected from a 4-entry speed table. It tracks the core's one-hot status flags, waits for each command to be acknowledged, and flags a sticky error on acknowledge timeout. Position: between board buttons and the watch core's command/status ports.

---
 rtl/watch_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/watch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_watch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: state encoding and shared widths for the stopwatch button front-end.
// Rev 1.0
`default_nettype none

package watch_pkg;

  localparam int SPEED_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_RUN    = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_WAIT_PAUSE  = 3'd3,
    ST_PAUSED      = 3'd4,
    ST_WAIT_RESUME = 3'd5,
    ST_WAIT_STOP   = 3'd6
  } state_t;

  function automatic logic is_wait(state_t s);
    return s inside {ST_WAIT_RUN, ST_WAIT_PAUSE, ST_WAIT_RESUME, ST_WAIT_STOP};
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debounce counter and registered rising-edge detect.
// Rev 1.0
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync0;
  logic          sync1;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      cnt     <= '0;
      o_level <= 1'b0;
      level_d <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync0   <= i_btn;
      sync1   <= sync0;
      // Any cycle that agrees with the current level restarts the count.
      if (sync1 == o_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC)) begin
        o_level <= sync1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= o_level;
      o_rise  <= o_level & ~level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/watch_ctrl.sv
// watch_ctrl: turns debounced buttons into acknowledged stopwatch commands with timeout.
// Rev 1.0
`default_nettype none

module watch_ctrl
  import watch_pkg::*;
#(
  parameter int          CNT_BIT = 31,
  parameter int          DEB_CYC = 4,
  parameter int          ACK_TO  = 16,
  parameter int unsigned TH0     = 100_000_000,
  parameter int unsigned TH1     = 10_000_000,
  parameter int unsigned TH2     = 1_000_000,
  parameter int unsigned TH3     = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_btn_start,
  input  logic               i_btn_pause,
  input  logic               i_btn_stop,
  input  logic [SPEED_W-1:0] i_speed_sel,
  input  logic               i_idle,
  input  logic               i_running,
  input  logic               i_pausing,
  input  logic               i_done,
  output logic               o_run,
  output logic               o_pause,
  output logic               o_restart,
  output logic               o_stop,
  output logic [CNT_BIT-1:0] o_cnt_th,
  output logic               o_busy,
  output logic               o_err
);

  localparam int ACK_W = $clog2(ACK_TO + 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_rise;

  assign btn_raw = {i_btn_stop, i_btn_pause, i_btn_start};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_raw[b]),
      .o_level (btn_level[b]),
      .o_rise  (btn_rise[b])
    );
  end

  // An edge only counts while its debounced level is still asserted.
  logic ev_start, ev_pause, ev_stop;
  logic [2:0] ev_raw;

  assign ev_raw   = btn_rise & btn_level;
  assign ev_stop  = ev_raw[2];
  assign ev_pause = ev_raw[1] & ~ev_raw[2];
  assign ev_start = ev_raw[0] & ~ev_raw[1] & ~ev_raw[2];

  state_t             state, state_n;
  logic [ACK_W-1:0]   ack_cnt;
  logic               timeout;
  logic               run_n, pause_n, restart_n, stop_n;
  logic               load_th, set_err, clr_err;
  logic [CNT_BIT-1:0] th_sel;

  assign timeout = (ack_cnt == ACK_W'(ACK_TO));
  assign o_busy  = is_wait(state);

  always_comb begin
    th_sel = CNT_BIT'(TH0);
    case (i_speed_sel)
      SPEED_W'(1): th_sel = CNT_BIT'(TH1);
      SPEED_W'(2): th_sel = CNT_BIT'(TH2);
      SPEED_W'(3): th_sel = CNT_BIT'(TH3);
      default:     th_sel = CNT_BIT'(TH0);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    run_n     = 1'b0;
    pause_n   = 1'b0;
    restart_n = 1'b0;
    stop_n    = 1'b0;
    load_th   = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_start) begin
          run_n   = 1'b1;
          load_th = 1'b1;
          clr_err = 1'b1;
          state_n = ST_WAIT_RUN;
        end
      end
      ST_WAIT_RUN:    if (i_running) state_n = ST_ACTIVE;
      ST_ACTIVE: begin
        // Core seen idle here means it was reset behind our back.
        if (i_idle) begin
          state_n = ST_IDLE;
        end else if (ev_stop) begin
          stop_n  = 1'b1;
          state_n = ST_WAIT_STOP;
        end else if (ev_pause) begin
          pause_n = 1'b1;
          state_n = ST_WAIT_PAUSE;
        end
      end
      ST_WAIT_PAUSE:  if (i_pausing) state_n = ST_PAUSED;
      ST_PAUSED: begin
        if (i_idle) begin
          state_n = ST_IDLE;
        end else if (ev_stop) begin
          stop_n  = 1'b1;
          state_n = ST_WAIT_STOP;
        end else if (ev_pause) begin
          restart_n = 1'b1;
          state_n   = ST_WAIT_RESUME;
        end
      end
      ST_WAIT_RESUME: if (i_running) state_n = ST_ACTIVE;
      ST_WAIT_STOP:   if (i_done || i_idle) state_n = ST_IDLE;
      default:        state_n = ST_IDLE;
    endcase
    if (is_wait(state) && (state_n == state) && timeout) begin
      state_n = ST_IDLE;
      set_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_cnt   <= '0;
      o_run     <= 1'b0;
      o_pause   <= 1'b0;
      o_restart <= 1'b0;
      o_stop    <= 1'b0;
      o_cnt_th  <= '0;
      o_err     <= 1'b0;
    end else begin
      if (is_wait(state_n) && (state_n == state)) begin
        ack_cnt <= ack_cnt + 1'b1;
      end else begin
        ack_cnt <= '0;
      end
      o_run     <= run_n;
      o_pause   <= pause_n;
      o_restart <= restart_n;
      o_stop    <= stop_n;
      if (load_th) o_cnt_th <= th_sel;
      if (set_err) begin
        o_err <= 1'b1;
      end else if (clr_err) begin
        o_err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_watch_ctrl.sv
// tb_watch_ctrl: vector table plus random button presses against a command-level model.
`default_nettype none

module tb_watch_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_start, btn_pause, btn_stop;
  logic [1:0]  speed_sel;
  logic        idle, running, pausing, done;
  logic        run, pause, restart, stop, busy, err;
  logic [30:0] cnt_th;

  logic        core_ack;
  logic [1:0]  core_st;

  int checks = 0;
  int errors = 0;
  int cur    = -1;

  typedef struct {
    logic [2:0]  btn;      // {stop, pause, start}
    logic [31:0] pat;      // raw level before edge i
    logic [1:0]  sel;
    bit          ack;      // core answers the command
    int          rst_at;   // window cycle to assert reset, -1 for none
    int          kind;     // 0 none, 1 run, 2 pause, 3 restart, 4 stop
    int          cyc;      // expected pulse cycle
    logic [30:0] th;       // expected held threshold
    bit          err;      // expected o_err at window end
    int          err_cyc;  // expected cycle of o_err rise, -1 unchecked
  } vec_t;

  vec_t tbl[$];

  watch_ctrl dut (
    .clk         (clk),
    .reset       (rst),
    .i_btn_start (btn_start),
    .i_btn_pause (btn_pause),
    .i_btn_stop  (btn_stop),
    .i_speed_sel (speed_sel),
    .i_idle      (idle),
    .i_running   (running),
    .i_pausing   (pausing),
    .i_done      (done),
    .o_run       (run),
    .o_pause     (pause),
    .o_restart   (restart),
    .o_stop      (stop),
    .o_cnt_th    (cnt_th),
    .o_busy      (busy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core: answers one cycle after a pulse; a core that fails to answer drops to idle.
  always @(posedge clk or posedge rst) begin
    if (rst) core_st <= 2'd0;
    else if (run || restart) core_st <= core_ack ? 2'd1 : 2'd0;
    else if (pause) core_st <= core_ack ? 2'd2 : 2'd0;
    else if (stop) core_st <= 2'd3;
  end
  assign idle    = (core_st == 2'd0);
  assign running = (core_st == 2'd1);
  assign pausing = (core_st == 2'd2);
  assign done    = (core_st == 2'd3);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0d, want %0d", nm, cur, act, exp);
    end
  endtask

  function automatic logic [30:0] th_of(input logic [1:0] s);
    case (s)
      2'd0: return 31'd100_000_000;
      2'd1: return 31'd10_000_000;
      2'd2: return 31'd1_000_000;
      default: return 31'd100;
    endcase
  endfunction

  function automatic vec_t mk(logic [2:0] btn, logic [31:0] pat, logic [1:0] sel, bit ack,
                              int rst_at, int kind, int cyc, logic [30:0] th, bit e, int ec);
    vec_t v;
    v.btn = btn; v.pat = pat; v.sel = sel; v.ack = ack; v.rst_at = rst_at;
    v.kind = kind; v.cyc = cyc; v.th = th; v.err = e; v.err_cyc = ec;
    return v;
  endfunction

  task automatic set_btn(input logic [2:0] m, input logic b);
    btn_start = m[0] & b;
    btn_pause = m[1] & b;
    btn_stop  = m[2] & b;
  endtask

  task automatic run_vec(input vec_t v);
    int npulse, pcyc, pkind, multi, errcyc, s;
    logic prev_err;
    logic [30:0] pth;
    npulse = 0; pcyc = -1; pkind = 0; multi = 0; errcyc = -1; pth = '0;
    @(negedge clk);
    core_ack  = v.ack;
    speed_sel = v.sel;
    prev_err  = err;
    set_btn(v.btn, v.pat[0]);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      s = int'(run) + int'(pause) + int'(restart) + int'(stop);
      if (s > 1) multi++;
      if (s >= 1) begin
        npulse++;
        if (pcyc < 0) begin
          pcyc  = i;
          pkind = run ? 1 : pause ? 2 : restart ? 3 : 4;
          pth   = cnt_th;
        end
      end
      if (err && !prev_err && errcyc < 0) errcyc = i;
      prev_err = err;
      if (i == v.rst_at) begin
        rst = 1'b1;
        #1;
        chk("reset_async", {run, pause, restart, stop, busy, err, cnt_th}, 0);
      end
      if (i == v.rst_at + 2) rst = 1'b0;
      set_btn(v.btn, (i < 31) ? v.pat[i+1] : 1'b0);
    end
    chk("pulse_count", npulse, (v.kind != 0) ? 1 : 0);
    chk("multi_pulse", multi, 0);
    if (v.kind != 0) begin
      chk("pulse_kind", pkind, v.kind);
      chk("pulse_cycle", pcyc, v.cyc);
      if (v.kind == 1) chk("run_th", pth, v.th);
    end
    if (v.err_cyc >= 0) chk("err_cycle", errcyc, v.err_cyc);
    chk("busy_end", busy, 0);
    chk("err_end", err, v.err);
    chk("th_end", cnt_th, v.th);
  endtask

  initial begin
    int   mode;  // 0 idle, 1 active, 2 paused
    logic [30:0] m_th;
    bit   m_err;
    rst = 1'b1;
    btn_start = 0; btn_pause = 0; btn_stop = 0;
    speed_sel = 2'd0;
    core_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {run, pause, restart, stop, busy, err, cnt_th}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    //                 btn     pat            sel  ack rst kind cyc th             err ecyc
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd2, 1, -1, 1,  8, 31'd1_000_000,   0, -1));
    tbl.push_back(mk(3'b010, 32'h0000_00FF, 2'd0, 1, -1, 2,  8, 31'd1_000_000,   0, -1));
    tbl.push_back(mk(3'b010, 32'h0000_00FF, 2'd0, 1, -1, 3,  8, 31'd1_000_000,   0, -1));
    tbl.push_back(mk(3'b100, 32'h0000_00FF, 2'd0, 1, -1, 4,  8, 31'd1_000_000,   0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_1FFB, 2'd0, 1, -1, 1, 11, 31'd100_000_000, 0, -1));
    tbl.push_back(mk(3'b110, 32'h0000_00FF, 2'd0, 1, -1, 4,  8, 31'd100_000_000, 0, -1));
    tbl.push_back(mk(3'b100, 32'h0000_00FF, 2'd0, 1, -1, 0,  0, 31'd100_000_000, 0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd3, 1, -1, 1,  8, 31'd100,         0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd1, 1, -1, 0,  0, 31'd100,         0, -1));
    tbl.push_back(mk(3'b010, 32'h0000_00FF, 2'd0, 1, -1, 2,  8, 31'd100,         0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd0, 1, -1, 0,  0, 31'd100,         0, -1));
    tbl.push_back(mk(3'b100, 32'h0000_00FF, 2'd0, 1, -1, 4,  8, 31'd100,         0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd1, 0, -1, 1,  8, 31'd10_000_000,  1, 25));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd2, 1, -1, 1,  8, 31'd1_000_000,   0, -1));
    tbl.push_back(mk(3'b010, 32'h0000_00FF, 2'd0, 1,  8, 2,  8, 31'd0,           0, -1));
    tbl.push_back(mk(3'b001, 32'h0000_00FF, 2'd3, 1, -1, 1,  8, 31'd100,         0, -1));
    tbl.push_back(mk(3'b100, 32'h0000_00FF, 2'd0, 1, -1, 4,  8, 31'd100,         0, -1));

    for (int k = 0; k < tbl.size(); k++) begin
      cur = k;
      run_vec(tbl[k]);
    end

    mode = 0; m_th = 31'd100; m_err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      int b, hold;
      b    = int'($urandom_range(0, 2));
      hold = int'($urandom_range(6, 14));
      v = mk(3'b001 << b, (32'd1 << hold) - 32'd1, 2'($urandom_range(0, 3)),
             !(b != 2 && $urandom_range(0, 5) == 0), -1, 0, 8, 31'd0, 1'b0, -1);
      case (b)
        0: if (mode == 0) v.kind = 1;
        1: if (mode == 1) v.kind = 2; else if (mode == 2) v.kind = 3;
        default: if (mode != 0) v.kind = 4;
      endcase
      if (v.kind != 0) begin
        if (v.kind == 1) begin
          m_th  = th_of(v.sel);
          m_err = 1'b0;
        end
        if (v.ack) begin
          mode = (v.kind == 2) ? 2 : (v.kind == 4) ? 0 : 1;
        end else begin
          mode  = 0;
          m_err = 1'b1;
          v.err_cyc = 25;
        end
      end
      v.th  = m_th;
      v.err = m_err;
      cur = 100 + k;
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
